index_sched: RTL
================

INDEX_SCHED -- requirements
Module: index_sched

Interface
REQ-001 SHALL have parameter RR, default 1: 1 = round-robin arbitration, 0 = fixed priority to port A.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port a_req, input, 1: address-generation request; held high until a_ack.
REQ-005 SHALL have port a_index, input, 3: index field 0..7.
REQ-006 SHALL have port a_addr, input, 13: AA field, sign-magnitude (bit12 = sign, 1 = negative).
REQ-007 SHALL have port a_ack, output, 1: one-cycle completion pulse.
REQ-008 SHALL have port a_m, output, 13: effective address M, valid only while a_ack is high.
REQ-009 SHALL have port a_err, output, 1: invalid index or magnitude over 4095, valid only while a_ack is high.
REQ-010 SHALL have port u_req, input, 1: index-update request; held high until u_ack.
REQ-011 SHALL have port u_op, input, 2: 00 ENT, 01 INC, 10 DEC, 11 reserved.
REQ-012 SHALL have port u_index, input, 3: target register, valid range 1..6.
REQ-013 SHALL have port u_val, input, 13: operand, sign-magnitude.
REQ-014 SHALL have port u_ack, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port u_ovf, output, 1: overflow or illegal op/index, valid only while u_ack is high.
REQ-016 SHALL have ports i1..i6, output, 13 each: current index register contents.

Function
REQ-017 SHALL hold six 13-bit sign-magnitude index registers and share one sign-magnitude adder between ports A and U.
REQ-018 SHALL implement FSM states IDLE, CALC and DONE: IDLE->CALC on grant, latching operands; CALC->DONE, registering the adder result; DONE->IDLE, pulsing the ack and performing write-back.
REQ-019 SHALL assert ack exactly 2 cycles after the edge on which the request was granted; back-to-back throughput SHALL be one op per 3 cycles.
REQ-020 SHALL, when both ports request in IDLE with RR=1, grant the port not served last; after reset the last-served pointer SHALL be U, so A wins first.
REQ-021 SHALL compute A as M = a_addr + rI[a_index], with rI[0] = +0; a_index 7 SHALL give a_err=1, a_m=+0.
REQ-022 SHALL implement ENT as rI := u_val, DEC as rI + (-u_val), INC as rI + u_val.
REQ-023 SHALL add equal-sign operands by summing magnitudes with the sign kept; a sum over 4095 SHALL be overflow.
REQ-024 SHALL add differing-sign operands as larger magnitude minus smaller, with the sign of the larger; a zero result SHALL take the sign of the first operand (register or AA).
REQ-025 SHALL, on A overflow, output a_m=+0 and a_err=1.
REQ-026 SHALL, on U overflow, u_op=11, or u_index 0 or 7, leave the register unchanged and set u_ovf=1.
REQ-027 SHALL complete a latched operation (ack and write-back) even if the request drops mid-operation.
REQ-028 SHALL make each write-back visible on i1..i6 and to the next granted op from the cycle after DONE.

Reset
REQ-029 SHALL, while rst_n is low, force state IDLE, i1..i6 = +0, a_ack/u_ack/a_err/u_ovf = 0, a_m = +0, and last-served = U, asynchronously; an in-flight op SHALL be discarded with no ack.

Structure
REQ-030 SHALL take the word width (13), magnitude max (4095), u_op codes and FSM state encoding from shared package mix_pkg.
REQ-031 SHALL instantiate one sub-module, sm_add, a combinational 13-bit sign-magnitude adder with overflow output.

Verification
REQ-032 SHALL cover: reset; a_req, index 0, a_addr +100 -> a_ack 2 cycles after grant, a_m=+100, a_err=0.
REQ-033 SHALL cover: ENT i3 -5; then A with index 3, a_addr +10 -> a_m=+5; then ENT i3 -10 and A +10 -> a_m=+0.
REQ-034 SHALL cover: ENT i1 +200; INC i1 +4000 -> u_ovf=1, i1 stays +200; DEC i1 +300 -> i1=-100.
REQ-035 SHALL cover: u_req and a_req high together after reset -> A acked first, U acked 3 cycles later; both held again -> A acked first again.
REQ-036 SHALL cover: a_index 7 -> a_err=1, a_m=+0; u_op 11 -> u_ovf=1, registers unchanged.
REQ-037 SHALL cover: rst_n low during CALC -> no ack, i1..i6=+0, FSM in IDLE on release.

Source files
------------

// File: rtl/mix_pkg.sv
// Shared definitions for the index scheduler: word/magnitude sizes, update opcodes and
// the scheduler FSM encoding.
package mix_pkg;

  // Sign-magnitude word: bit 12 is the sign (1 = negative), bits 11:0 the magnitude.
  localparam int unsigned W      = 13;
  localparam int unsigned MagW   = 12;
  localparam int unsigned MagMax = 4095;

  typedef enum logic [1:0] {
    OpEnt = 2'b00,
    OpInc = 2'b01,
    OpDec = 2'b10,
    OpRsv = 2'b11
  } uop_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/sm_add.sv
// Combinational 13-bit sign-magnitude adder.
//   x_i, y_i : operands (x_i is the "first" operand; it gives the sign of a zero result
//              when the operand signs differ)
//   sum_o    : sign-magnitude sum (meaningless when ovf_o is set)
//   ovf_o    : result magnitude exceeds MagMax
module sm_add
  import mix_pkg::*;
(
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic            sx, sy;
  logic [MagW-1:0] mx, my;
  logic [MagW:0]   mag_sum;

  assign sx      = x_i[W-1];
  assign sy      = y_i[W-1];
  assign mx      = x_i[MagW-1:0];
  assign my      = y_i[MagW-1:0];
  assign mag_sum = {1'b0, mx} + {1'b0, my};

  always_comb begin
    sum_o = '0;
    ovf_o = 1'b0;
    if (sx == sy) begin
      sum_o = {sx, mag_sum[MagW-1:0]};
      ovf_o = (mag_sum > (MagW + 1)'(MagMax));
    end else if (mx > my) begin
      sum_o = {sx, mx - my};
    end else if (my > mx) begin
      sum_o = {sy, my - mx};
    end else begin
      // Exact cancellation keeps the first operand's sign.
      sum_o = {sx, {MagW{1'b0}}};
    end
  end

endmodule

// File: rtl/index_sched.sv
// Index register file with two requesters sharing one sign-magnitude adder.
//   Port A: effective-address generation, M = a_addr + rI[a_index] (rI[0] = +0).
//   Port U: index update (ENT / INC / DEC) of registers 1..6.
//   clk, rst_n        : clock, asynchronous active-low reset
//   a_req/a_index/a_addr -> a_ack/a_m/a_err   (outputs valid while a_ack)
//   u_req/u_op/u_index/u_val -> u_ack/u_ovf  (outputs valid while u_ack)
//   i1..i6            : current index register contents
// Each op walks IDLE -> CALC -> DONE; ack is high during DONE and write-back lands on
// the DONE -> IDLE edge.
module index_sched
  import mix_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_req,
  input  logic [2:0]   a_index,
  input  logic [W-1:0] a_addr,
  output logic         a_ack,
  output logic [W-1:0] a_m,
  output logic         a_err,
  input  logic         u_req,
  input  logic [1:0]   u_op,
  input  logic [2:0]   u_index,
  input  logic [W-1:0] u_val,
  output logic         u_ack,
  output logic         u_ovf,
  output logic [W-1:0] i1,
  output logic [W-1:0] i2,
  output logic [W-1:0] i3,
  output logic [W-1:0] i4,
  output logic [W-1:0] i5,
  output logic [W-1:0] i6
);

  state_e         state_q, state_d;
  logic           own_a_q;   // current op belongs to port A
  logic           last_a_q;  // last granted port was A
  logic [W-1:0]   x_q, y_q;
  logic           ent_q, bad_q;
  logic [2:0]     tgt_q;
  logic [W-1:0]   res_q;
  logic           err_q;
  logic [W-1:0]   rf_q [1:6];

  logic           grant_a, grant_u;
  logic [W-1:0]   a_reg, u_reg;
  logic [W-1:0]   add_sum;
  logic           add_ovf;
  logic           u_bad;

  sm_add u_add (
    .x_i   (x_q),
    .y_i   (y_q),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  // Register reads; indices 0 and 7 read as +0.
  always_comb begin
    a_reg = '0;
    u_reg = '0;
    for (int i = 1; i <= 6; i++) begin
      if (a_index == 3'(i)) a_reg = rf_q[i];
      if (u_index == 3'(i)) u_reg = rf_q[i];
    end
  end

  assign u_bad = (u_op == OpRsv) || (u_index == 3'd0) || (u_index == 3'd7);

  // With RR, A loses a tie only if it was served last.
  always_comb begin
    grant_a = 1'b0;
    grant_u = 1'b0;
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        grant_a = a_req && (!u_req || !RR || !last_a_q);
        grant_u = u_req && !grant_a;
        if (grant_a || grant_u) state_d = StCalc;
      end
      StCalc:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      own_a_q  <= 1'b0;
      last_a_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      ent_q    <= 1'b0;
      bad_q    <= 1'b0;
      tgt_q    <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 1; i <= 6; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (grant_a) begin
        own_a_q  <= 1'b1;
        last_a_q <= 1'b1;
        x_q      <= a_addr;
        y_q      <= a_reg;
        ent_q    <= 1'b0;
        bad_q    <= (a_index == 3'd7);
        tgt_q    <= a_index;
      end else if (grant_u) begin
        own_a_q  <= 1'b0;
        last_a_q <= 1'b0;
        x_q      <= u_reg;
        y_q      <= (u_op == OpDec) ? {~u_val[W-1], u_val[MagW-1:0]} : u_val;
        ent_q    <= (u_op == OpEnt);
        bad_q    <= u_bad;
        tgt_q    <= u_index;
      end
      if (state_q == StCalc) begin
        if (bad_q) begin
          res_q <= '0;
          err_q <= 1'b1;
        end else if (ent_q) begin
          res_q <= y_q;
          err_q <= 1'b0;
        end else begin
          res_q <= add_ovf ? '0 : add_sum;
          err_q <= add_ovf;
        end
      end
      if (state_q == StDone && !own_a_q && !err_q) begin
        for (int i = 1; i <= 6; i++) begin
          if (tgt_q == 3'(i)) rf_q[i] <= res_q;
        end
      end
    end
  end

  always_comb begin
    a_ack = (state_q == StDone) && own_a_q;
    u_ack = (state_q == StDone) && !own_a_q;
    a_m   = a_ack ? res_q : '0;
    a_err = a_ack && err_q;
    u_ovf = u_ack && err_q;
  end

  assign i1 = rf_q[1];
  assign i2 = rf_q[2];
  assign i3 = rf_q[3];
  assign i4 = rf_q[4];
  assign i5 = rf_q[5];
  assign i6 = rf_q[6];

endmodule
